adder_word_sequencer: RTL and testbench

Multi-cycle wide adder controller. It sequences one shared adder_16bit instance across NUM_WORDS 16-bit slices, least-significant word first, chaining each slice's overflow into the next slice's carry_in. It presents a start/busy/done handshake to the surrounding datapath, so wide additions reuse a single 16-bit adder.

---
 rtl/adder_seq_pkg.sv | 12 +
 rtl/adder_word_sequencer_if.sv | 29 ++
 rtl/adder_16bit.sv | 15 +
 rtl/adder_word_sequencer.sv | 98 +++++++++
 tb/tb_adder_word_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the multi-word adder sequencer.
package adder_seq_pkg;

  localparam int unsigned WORD_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/adder_word_sequencer_if.sv
// start/busy/done handshake and wide operand/result bus of the word sequencer.
interface adder_word_sequencer_if
  import adder_seq_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
);

  localparam int unsigned TOTAL_BITS = WORD_BITS * NUM_WORDS;

  logic                  start;
  logic [TOTAL_BITS-1:0] a;
  logic [TOTAL_BITS-1:0] b;
  logic                  carry_in;
  logic                  busy;
  logic                  done;
  logic [TOTAL_BITS-1:0] sum;
  logic                  overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );

endinterface

// File: rtl/adder_16bit.sv
// Combinational 16-bit adder with carry in and carry out.
module adder_16bit
  import adder_seq_pkg::*;
(
  input  logic [WORD_BITS-1:0] a,
  input  logic [WORD_BITS-1:0] b,
  input  logic                 carry_in,
  output logic [WORD_BITS-1:0] sum,
  output logic                 overflow
);

  assign {overflow, sum} = (WORD_BITS + 1)'(a) + (WORD_BITS + 1)'(b)
                         + (WORD_BITS + 1)'(carry_in);

endmodule

// File: rtl/adder_word_sequencer.sv
// Wide adder that walks one shared 16-bit adder across NUM_WORDS slices,
// least-significant word first, rippling the carry between slices.
module adder_word_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
) (
  input logic                    clk,
  input logic                    n_rst,
  adder_word_sequencer_if.slave  bus
);

  localparam int unsigned TOTAL_BITS = WORD_BITS * NUM_WORDS;
  localparam int unsigned IDX_W      = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  seq_state_t            state;
  seq_state_t            next_state;
  logic [IDX_W-1:0]      idx;
  logic [TOTAL_BITS-1:0] a_reg;
  logic [TOTAL_BITS-1:0] b_reg;
  logic                  carry_reg;
  logic [TOTAL_BITS-1:0] sum_reg;
  logic                  overflow_reg;

  logic [WORD_BITS-1:0]  word_sum;
  logic                  word_ovf;

  adder_16bit u_adder (
    .a        (a_reg[idx*WORD_BITS +: WORD_BITS]),
    .b        (b_reg[idx*WORD_BITS +: WORD_BITS]),
    .carry_in (carry_reg),
    .sum      (word_sum),
    .overflow (word_ovf)
  );

  // State register plus the word counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      idx          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      sum_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.carry_in;
            idx       <= '0;
          end
        end
        ADD: begin
          sum_reg[idx*WORD_BITS +: WORD_BITS] <= word_sum;
          carry_reg                           <= word_ovf;
          if (idx == LAST_IDX) begin
            overflow_reg <= word_ovf;
            idx          <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = ADD;
      ADD:     if (idx == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      ADD:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.sum      = sum_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed self-checking bench for adder_word_sequencer with NUM_WORDS=4.
module tb_adder_word_sequencer;

  localparam int unsigned N = 4;

  logic clk;
  logic n_rst;
  int   compared;
  int   mismatched;

  adder_word_sequencer_if #(.NUM_WORDS(N)) bus ();

  adder_word_sequencer #(.NUM_WORDS(N)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one addition, scramble inputs while busy, then check latency and result.
  task automatic run_add(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic cin, input logic [63:0] exp_sum, input logic exp_ovf);
    int cyc;
    int busy_cnt;
    bus.a        = av;
    bus.b        = bv;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    bus.carry_in = ~cin;
    cyc      = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      step();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    step();
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, "_sum_hold"}, bus.sum, exp_sum);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    compared     = 0;
    mismatched   = 0;
    n_rst        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    step();
    step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    n_rst = 1'b1;
    step();

    run_add("zero", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    run_add("word_carry", 64'h0000_0000_0000_FFFF, 64'h4, 1'b0,
            64'h0000_0000_0001_0003, 1'b0);
    run_add("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    run_add("big_ovf", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFB, 1'b1);

    // Second start while busy must be ignored.
    bus.a        = 64'd3;
    bus.b        = 64'd4;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.a     = 64'd8;
    bus.b     = 64'hFFFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        done_cnt++;
        check("ignore_start_sum", bus.sum, 64'h7);
        check("ignore_start_overflow", 64'(bus.overflow), 64'd0);
      end
      step();
    end
    check("ignore_start_done_count", 64'(done_cnt), 64'd1);

    // Start held high restarts every N+2 cycles.
    bus.a        = 64'd1;
    bus.b        = 64'd2;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    first_done   = -1;
    second_done  = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    bus.start = 1'b0;
    check("held_start_period", 64'(second_done - first_done), 64'd6);
    check("held_start_sum", bus.sum, 64'h3);
    for (int i = 0; i < 8; i++) step();

    // Reset on the second ADD cycle discards the partial result.
    bus.a        = 64'h1234_5678_9ABC_DEF0;
    bus.b        = 64'h1;
    bus.carry_in = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    n_rst = 1'b0;
    step();
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_sum", bus.sum, 64'd0);
    check("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    n_rst = 1'b1;
    step();
    run_add("after_rst", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
